rx_sym_slicer_mer: RTL and testbench

- Downstream stage of the 21-tap SRRC receive filter; consumes its 1s17 output at 4 samples/symbol.
- Decimates to one sample per symbol at a switch-selected phase and slices it to a 4-ASK decision.
- Estimates the slicer reference level from the block mean of |x|, and measures block mean-squared decision error for MER reporting.

---
 rtl/rx_sym_slicer_mer.sv | 130 +++++++++++++
 tb/tb_rx_sym_slicer_mer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_sym_slicer_mer.sv
// rtl/rx_sym_slicer_mer.sv - symbol-rate decimator, 4-ASK slicer, reference-level and MER estimator
// Picks one of four filter-output phases per symbol, slices it against a running 2a threshold.
module rx_sym_slicer_mer #(
    parameter int          LOG2_N   = 10,
    parameter logic [17:0] REF_INIT = 18'sd32768
) (
    input  logic               clk,
    input  logic               reset,
    input  logic        [1:0]  sw,
    input  logic signed [17:0] x_in,
    output logic        [1:0]  sym_out,
    output logic               sym_valid,
    output logic        [17:0] ref_level,
    output logic        [17:0] mse_out,
    output logic               mse_valid
);
    localparam int AW = 17 + LOG2_N;
    localparam int QW = 18 + LOG2_N;
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    logic        [1:0]        phase_q;
    logic signed [17:0]       x_sym_q;
    logic                     cap_q;
    logic        [1:0]        sym_q;
    logic                     sym_valid_q;
    logic        [17:0]       ref_q;
    logic        [17:0]       mse_q;
    logic                     mse_valid_q;
    logic        [LOG2_N-1:0] cnt_q;
    logic        [AW-1:0]     acc_abs_q;
    logic        [QW-1:0]     acc_sq_q;

    logic        [16:0]       abs_x;
    logic                     outer;
    logic                     neg;
    logic        [18:0]       mag;
    logic signed [19:0]       ideal;
    logic signed [19:0]       err_w;
    logic signed [17:0]       err;
    logic signed [35:0]       prod;
    logic        [17:0]       sq;
    logic        [1:0]        dec;
    logic        [AW-1:0]     sum_abs;
    logic        [AW-1:0]     mean_abs;
    logic        [QW-1:0]     sum_sq;
    logic        [QW-1:0]     mean_sq;
    logic        [17:0]       ref_d;
    logic        [17:0]       mse_d;

    always_comb begin
        neg = x_sym_q[17];
        // The most negative code has no positive twin; clamp its magnitude.
        if (x_sym_q == 18'sh20000) begin
            abs_x = 17'h1FFFF;
        end else if (neg) begin
            abs_x = 17'(-x_sym_q);
        end else begin
            abs_x = x_sym_q[16:0];
        end
        outer = ({1'b0, abs_x} >= ref_q);
        mag   = outer ? ({1'b0, ref_q} + {2'b0, ref_q[17:1]}) : {2'b0, ref_q[17:1]};
        ideal = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        err_w = {{2{x_sym_q[17]}}, x_sym_q} - ideal;
        if (err_w > 20'sd131071) begin
            err = 18'sh1FFFF;
        end else if (err_w < -20'sd131072) begin
            err = 18'sh20000;
        end else begin
            err = err_w[17:0];
        end
        prod = err * err;
        sq   = 18'(prod >>> 17);
        dec  = {~neg, outer ^ neg};
    end

    always_comb begin
        sum_abs  = acc_abs_q + AW'(abs_x);
        mean_abs = sum_abs >> LOG2_N;
        sum_sq   = acc_sq_q + QW'(sq);
        mean_sq  = sum_sq >> LOG2_N;
        ref_d    = (mean_abs > AW'(17'h1FFFF)) ? 18'h1FFFF : 18'(mean_abs);
        mse_d    = (mean_sq > QW'(18'h3FFFF)) ? 18'h3FFFF : 18'(mean_sq);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= 2'd0;
            x_sym_q     <= '0;
            cap_q       <= 1'b0;
            sym_q       <= 2'd0;
            sym_valid_q <= 1'b0;
            ref_q       <= REF_INIT;
            mse_q       <= '0;
            mse_valid_q <= 1'b0;
            cnt_q       <= '0;
            acc_abs_q   <= '0;
            acc_sq_q    <= '0;
        end else begin
            phase_q     <= phase_q + 2'd1;
            cap_q       <= (phase_q == sw);
            sym_valid_q <= cap_q;
            mse_valid_q <= 1'b0;
            if (phase_q == sw) begin
                x_sym_q <= x_in;
            end
            if (cap_q) begin
                sym_q <= dec;
                // Last symbol of a block: publish the means and start a fresh block.
                if (cnt_q == CNT_LAST) begin
                    ref_q       <= ref_d;
                    mse_q       <= mse_d;
                    mse_valid_q <= 1'b1;
                    acc_abs_q   <= '0;
                    acc_sq_q    <= '0;
                    cnt_q       <= '0;
                end else begin
                    acc_abs_q <= sum_abs;
                    acc_sq_q  <= sum_sq;
                    cnt_q     <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign sym_out   = sym_q;
    assign sym_valid = sym_valid_q;
    assign ref_level = ref_q;
    assign mse_out   = mse_q;
    assign mse_valid = mse_valid_q;
endmodule

// File: tb/tb_rx_sym_slicer_mer.sv
// tb/tb_rx_sym_slicer_mer.sv - randomized self-checking bench for rx_sym_slicer_mer
module tb_rx_sym_slicer_mer;
    localparam int LOG2_N = 2;
    localparam int N      = 4;

    logic               clk   = 1'b0;
    logic               reset = 1'b1;
    logic        [1:0]  sw    = 2'd0;
    logic signed [17:0] x_in  = '0;
    logic        [1:0]  sym_out;
    logic               sym_valid;
    logic        [17:0] ref_level;
    logic        [17:0] mse_out;
    logic               mse_valid;

    rx_sym_slicer_mer #(.LOG2_N(LOG2_N), .REF_INIT(18'sd32768)) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .x_in      (x_in),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .ref_level (ref_level),
        .mse_out   (mse_out),
        .mse_valid (mse_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: stream of samples in, expected outputs after each edge.
    int     m_phase, m_pend_x, m_cnt, m_ref, m_mse, m_sym;
    bit     m_pend_valid, m_valid, m_mse_valid;
    longint m_sum_abs, m_sum_sq;

    function automatic void model_reset();
        m_phase = 0; m_pend_valid = 0; m_pend_x = 0; m_cnt = 0;
        m_sum_abs = 0; m_sum_sq = 0; m_ref = 32768; m_mse = 0;
        m_sym = 0; m_valid = 0; m_mse_valid = 0;
    endfunction

    function automatic void model_symbol(input int x);
        int ax, mag, ideal, err;
        bit outer, neg;
        longint sq;
        neg   = (x < 0);
        ax    = neg ? -x : x;
        if (ax > 131071) ax = 131071;
        outer = (ax >= m_ref);
        mag   = outer ? (m_ref + m_ref / 2) : (m_ref / 2);
        ideal = neg ? -mag : mag;
        err   = x - ideal;
        if (err > 131071) err = 131071;
        if (err < -131072) err = -131072;
        sq    = (longint'(err) * err) / 131072;
        m_sym = neg ? (outer ? 0 : 1) : (outer ? 3 : 2);
        m_valid = 1;
        m_sum_abs += ax;
        m_sum_sq  += sq;
        m_cnt++;
        if (m_cnt == N) begin
            m_ref = int'(m_sum_abs / N);
            if (m_ref > 131071) m_ref = 131071;
            m_mse = int'(m_sum_sq / N);
            m_mse_valid = 1;
            m_cnt = 0; m_sum_abs = 0; m_sum_sq = 0;
        end
    endfunction

    function automatic logic [39:0] exp_vec();
        logic [1:0]  s;
        logic [17:0] r, m;
        s = m_sym[1:0]; r = m_ref[17:0]; m = m_mse[17:0];
        return {m_valid, s, r, m_mse_valid, m};
    endfunction

    function automatic logic [39:0] dut_vec();
        return {sym_valid, sym_out, ref_level, mse_valid, mse_out};
    endfunction

    // Drive one sample, advance the model across the coming edge, then settle at negedge.
    task automatic cycle(input int x, input int s);
        x_in = 18'(x);
        sw   = 2'(s);
        m_valid = 0;
        m_mse_valid = 0;
        if (m_pend_valid) model_symbol(m_pend_x);
        m_pend_valid = (m_phase == s);
        if (m_pend_valid) m_pend_x = x;
        m_phase = (m_phase + 1) % 4;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_reset(output logic [39:0] v);
        #2 reset = 1'b1;
        #1 v = dut_vec();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    function automatic int rand_x();
        int r;
        r = int'($urandom_range(0, 262143)) - 131072;
        return r;
    endfunction

    task automatic test_reset();
        logic [39:0] v;
        int pulses, seen;
        for (int i = 0; i < 11; i++) begin
            cycle(rand_x(), 1);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_prerun cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        apply_reset(v);
        n_tests++;
        if (v !== {1'b0, 2'b00, 18'd32768, 1'b0, 18'd0}) begin
            n_fail++;
            $display("FAIL reset_values got=%h exp=%h", v, {1'b0, 2'b00, 18'd32768, 1'b0, 18'd0});
        end
        pulses = 0; seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            cycle(rand_x(), 1);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (sym_valid) pulses++;
            if (mse_valid) seen = 1;
        end
        n_tests++;
        if (seen != 1 || pulses != 4) begin
            n_fail++;
            $display("FAIL reset_first_block seen=%0d symbols=%0d required seen=1 symbols=4", seen, pulses);
        end
    endtask

    task automatic test_phase_select();
        logic [39:0] v;
        int last, n2, nbad, s, first_ref, blk;
        apply_reset(v);
        last = -1; n2 = 0; nbad = 0; s = 2; first_ref = -1; blk = 0;
        for (int i = 0; i < 48; i++) begin
            if (i >= 24 && m_phase == 3) s = 0;
            cycle(i, s);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL phase_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (sym_valid) begin
                if (last >= 0) begin
                    if (cyc - last == 2) n2++;
                    else if (cyc - last != 4) nbad++;
                end
                last = cyc;
            end
            if (mse_valid && blk == 0) begin
                first_ref = int'(ref_level);
                blk = 1;
            end
        end
        n_tests++;
        if (n2 != 1 || nbad != 0) begin
            n_fail++;
            $display("FAIL phase_spacing short_gaps=%0d odd_gaps=%0d required 1 and 0", n2, nbad);
        end
        n_tests++;
        if (first_ref != 8) begin
            n_fail++;
            $display("FAIL phase_captures first_ref=%0d required 8", first_ref);
        end
    endtask

    task automatic test_dc_outer();
        logic [39:0] v;
        int blk;
        apply_reset(v);
        blk = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(49152, 0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL dc_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (sym_valid && sym_out !== 2'b11) begin
                n_fail++;
                $display("FAIL dc_sym cyc=%0d got=%b required 11", cyc, sym_out);
            end
            if (mse_valid) begin
                blk++;
                n_tests++;
                if (blk == 1 && (mse_out !== 18'd0 || ref_level !== 18'd49152)) begin
                    n_fail++;
                    $display("FAIL dc_block1 mse=%0d ref=%0d required 0 49152", mse_out, ref_level);
                end
                if (blk == 2 && (mse_out !== 18'd4608 || ref_level !== 18'd49152)) begin
                    n_fail++;
                    $display("FAIL dc_block2 mse=%0d ref=%0d required 4608 49152", mse_out, ref_level);
                end
            end
        end
        n_tests++;
        if (blk < 2) begin
            n_fail++;
            $display("FAIL dc_blocks got=%0d required >=2", blk);
        end
    endtask

    task automatic test_negative_inner();
        logic [39:0] v;
        int blk, ref1, n0;
        apply_reset(v);
        blk = 0; ref1 = -1; n0 = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(-16384, 3);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL neg_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (sym_valid) begin
                if (blk == 0 && sym_out !== 2'b01) begin
                    n_fail++;
                    $display("FAIL neg_inner cyc=%0d got=%b required 01", cyc, sym_out);
                end
                if (blk > 0) begin
                    n0++;
                    if (sym_out !== 2'b00) begin
                        n_fail++;
                        $display("FAIL neg_outer cyc=%0d got=%b required 00", cyc, sym_out);
                    end
                end
            end
            if (mse_valid) begin
                if (blk == 0) ref1 = int'(ref_level);
                blk++;
            end
        end
        n_tests++;
        if (ref1 != 16384 || n0 == 0) begin
            n_fail++;
            $display("FAIL neg_ref ref=%0d outer_syms=%0d required 16384 and >0", ref1, n0);
        end
    endtask

    task automatic test_saturation_ties();
        logic [39:0] v;
        logic [1:0]  syms[$];
        int xs[4];
        int ref1;
        xs = '{-131072, 32768, 0, -131072};
        apply_reset(v);
        ref1 = -1;
        for (int i = 0; i < 16; i++) begin
            cycle((i % 4 == 0) ? xs[i / 4] : rand_x(), 0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL sat_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (sym_valid) syms.push_back(sym_out);
            if (mse_valid && ref1 < 0) ref1 = int'(ref_level);
        end
        n_tests++;
        if (syms.size() < 3 || syms[0] !== 2'b00 || syms[1] !== 2'b11 || syms[2] !== 2'b10) begin
            n_fail++;
            $display("FAIL sat_ties count=%0d first=%b,%b,%b required 00,11,10", syms.size(),
                     (syms.size() > 0) ? syms[0] : 2'bxx, (syms.size() > 1) ? syms[1] : 2'bxx,
                     (syms.size() > 2) ? syms[2] : 2'bxx);
        end
        n_tests++;
        if (ref1 != 73727) begin
            n_fail++;
            $display("FAIL sat_abs ref=%0d required 73727", ref1);
        end
    endtask

    task automatic test_random();
        logic [39:0] v;
        int s, x, mode;
        s = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                apply_reset(v);
                n_tests++;
                if (v !== {1'b0, 2'b00, 18'd32768, 1'b0, 18'd0}) begin
                    n_fail++;
                    $display("FAIL rand_reset got=%h", v);
                end
            end
            if ($urandom_range(0, 15) == 0) s = int'($urandom_range(0, 3));
            mode = int'($urandom_range(0, 3));
            case (mode)
                0:       x = rand_x();
                1:       x = int'($urandom_range(0, 8191)) - 4096;
                2:       x = ($urandom_range(0, 1) != 0) ? m_ref : -m_ref;
                default: x = ($urandom_range(0, 1) != 0) ? -131072 : 131071;
            endcase
            if (x > 131071) x = 131071;
            if (x < -131072) x = -131072;
            cycle(x, s);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rand_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_phase_select();
        test_dc_outer();
        test_negative_inner();
        test_saturation_ties();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
